router_req_issuer: RTL and testbench

- Upstream feeder for the router subsystem.
- Accepts transfer descriptors (source/destination address plus DFX region) from a control master into a small FIFO.
- Presents descriptors one at a time on the router request interface: router_start_req, router_scr_addr, router_dst_addr, router_src_dfx, router_dst_dfx.
- Holds each request until the router acknowledges it, then waits for completion before issuing the next one.

---
 rtl/router_req_pkg.sv | 21 ++
 rtl/router_req_issuer_if.sv | 37 +++
 rtl/router_desc_fifo.sv | 48 ++++
 rtl/router_req_issuer.sv | 138 +++++++++++++
 tb/tb_router_req_issuer.sv | 520 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/router_req_pkg.sv
// Shared types for the router request issuer: descriptor layout and FSM states.
package router_req_pkg;

  localparam int unsigned DEF_ADDR_W = 10;
  localparam int unsigned DEF_DFX_W  = 2;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0] src_addr;
    logic [DEF_ADDR_W-1:0] dst_addr;
    logic [DEF_DFX_W-1:0]  src_dfx;
    logic [DEF_DFX_W-1:0]  dst_dfx;
  } router_desc_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT_DONE,
    GAP
  } req_state_t;

endpackage

// File: rtl/router_req_issuer_if.sv
// Descriptor intake and router request signals; slave is the issuer's view, master the
// view of the block driving descriptors and modelling the router.
interface router_req_issuer_if
  import router_req_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DFX_W  = DEF_DFX_W
);
  logic              desc_valid;
  logic              desc_ready;
  logic [ADDR_W-1:0] desc_src_addr;
  logic [ADDR_W-1:0] desc_dst_addr;
  logic [DFX_W-1:0]  desc_src_dfx;
  logic [DFX_W-1:0]  desc_dst_dfx;

  logic              router_start_req;
  logic [ADDR_W-1:0] router_scr_addr;
  logic [ADDR_W-1:0] router_dst_addr;
  logic [DFX_W-1:0]  router_src_dfx;
  logic [DFX_W-1:0]  router_dst_dfx;
  logic              router_ack;
  logic              router_done;

  modport slave (
    input  desc_valid, desc_src_addr, desc_dst_addr, desc_src_dfx, desc_dst_dfx,
    input  router_ack, router_done,
    output desc_ready,
    output router_start_req, router_scr_addr, router_dst_addr, router_src_dfx, router_dst_dfx
  );

  modport master (
    output desc_valid, desc_src_addr, desc_dst_addr, desc_src_dfx, desc_dst_dfx,
    output router_ack, router_done,
    input  desc_ready,
    input  router_start_req, router_scr_addr, router_dst_addr, router_src_dfx, router_dst_dfx
  );
endinterface

// File: rtl/router_desc_fifo.sv
// Synchronous descriptor FIFO with wrap-bit pointers; pushes while full and pops while
// empty are ignored.
module router_desc_fifo
  import router_req_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter type         desc_t     = router_desc_t
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  desc_t                        wdata,
  output desc_t                        rdata,
  output logic                         full,
  output logic                         empty,
  output logic [$clog2(FIFO_DEPTH):0]  count
);
  localparam int unsigned IDX_W = $clog2(FIFO_DEPTH);

  desc_t            mem [FIFO_DEPTH];
  logic [IDX_W:0]   wptr_q, rptr_q;
  logic             do_push, do_pop;

  assign full    = (wptr_q[IDX_W] != rptr_q[IDX_W]) &&
                   (wptr_q[IDX_W-1:0] == rptr_q[IDX_W-1:0]);
  assign empty   = (wptr_q == rptr_q);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign count   = wptr_q - rptr_q;
  assign rdata   = mem[rptr_q[IDX_W-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (do_push) wptr_q <= wptr_q + 1'b1;
      if (do_pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset: empty pointers make stale entries unreachable.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr_q[IDX_W-1:0]] <= wdata;
  end

endmodule

// File: rtl/router_req_issuer.sv
// Feeds queued descriptors to the router one at a time. Define ROUTER_REQ_TIMEOUT_EN to
// add a watchdog that aborts a request stuck waiting for ack/done.
module router_req_issuer
  import router_req_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned ADDR_W         = DEF_ADDR_W,
  parameter int unsigned DFX_W          = DEF_DFX_W,
  parameter int unsigned TIMEOUT_CYCLES = 256
) (
  input  logic                         clk,
  input  logic                         rst,
  router_req_issuer_if.slave           bus,
  output logic                         busy,
  output logic [$clog2(FIFO_DEPTH):0]  fifo_count,
  output logic [15:0]                  done_count,
  output logic                         err_illegal,
  output logic                         err_timeout
);
  typedef struct packed {
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [DFX_W-1:0]  src_dfx;
    logic [DFX_W-1:0]  dst_dfx;
  } desc_t;

  req_state_t state_q;
  desc_t      in_desc, head, out_q;
  logic       full, empty, accept, illegal, push, pop;
  logic       start_q, err_illegal_q, tmo_hit;
  logic [15:0] done_q;

  assign in_desc = '{src_addr: bus.desc_src_addr, dst_addr: bus.desc_dst_addr,
                     src_dfx:  bus.desc_src_dfx,  dst_dfx:  bus.desc_dst_dfx};

  // Illegal descriptors complete the handshake but never reach the FIFO.
  assign accept  = bus.desc_valid && !full;
  assign illegal = (bus.desc_src_dfx == bus.desc_dst_dfx);
  assign push    = accept && !illegal;
  assign pop     = (state_q == IDLE) && !empty;

  router_desc_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .desc_t     (desc_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata (in_desc),
    .rdata (head),
    .full  (full),
    .empty (empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      start_q       <= 1'b0;
      out_q         <= '0;
      done_q        <= '0;
      err_illegal_q <= 1'b0;
    end else begin
      err_illegal_q <= accept && illegal;
      unique case (state_q)
        IDLE: begin
          if (!empty) begin
            out_q   <= head;
            start_q <= 1'b1;
            state_q <= ISSUE;
          end
        end
        ISSUE: begin
          if (bus.router_ack) begin
            start_q <= 1'b0;
            if (bus.router_done) begin
              done_q  <= done_q + 16'd1;
              state_q <= GAP;
            end else begin
              state_q <= WAIT_DONE;
            end
          end else if (tmo_hit) begin
            start_q <= 1'b0;
            state_q <= GAP;
          end
        end
        WAIT_DONE: begin
          if (bus.router_done) begin
            done_q  <= done_q + 16'd1;
            state_q <= GAP;
          end else if (tmo_hit) begin
            state_q <= GAP;
          end
        end
        GAP:     state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef ROUTER_REQ_TIMEOUT_EN
  localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TMO_W-1:0] tmo_q;
  logic             err_timeout_q;

  assign tmo_hit = (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));

  // Counter restarts each time a request is issued; the awaited event wins over the limit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_q         <= '0;
      err_timeout_q <= 1'b0;
    end else begin
      tmo_q         <= (state_q == ISSUE || state_q == WAIT_DONE) ? tmo_q + 1'b1 : '0;
      err_timeout_q <= tmo_hit && ((state_q == ISSUE && !bus.router_ack) ||
                                   (state_q == WAIT_DONE && !bus.router_done));
    end
  end

  assign err_timeout = err_timeout_q;
`else
  assign tmo_hit     = 1'b0;
  assign err_timeout = 1'b0;
`endif

  assign bus.desc_ready       = !full;
  assign bus.router_start_req = start_q;
  assign bus.router_scr_addr  = out_q.src_addr;
  assign bus.router_dst_addr  = out_q.dst_addr;
  assign bus.router_src_dfx   = out_q.src_dfx;
  assign bus.router_dst_dfx   = out_q.dst_dfx;
  assign busy                 = (state_q != IDLE);
  assign done_count           = done_q;
  assign err_illegal          = err_illegal_q;

endmodule

// File: tb/tb_router_req_issuer.sv
// Bench for router_req_issuer: directed latency/boundary scenarios plus a randomized run
// scored against a transaction-level model of issued descriptors and completions.
module tb_router_req_issuer;
  localparam int unsigned FIFO_DEPTH     = 4;
  localparam int unsigned ADDR_W         = 10;
  localparam int unsigned DFX_W          = 2;
  localparam int unsigned TIMEOUT_CYCLES = 8;

  typedef struct packed {
    logic [ADDR_W-1:0] src;
    logic [ADDR_W-1:0] dst;
    logic [DFX_W-1:0]  sdfx;
    logic [DFX_W-1:0]  ddfx;
  } tdesc_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        busy;
  logic [2:0]  fifo_count;
  logic [15:0] done_count;
  logic        err_illegal, err_timeout;

  router_req_issuer_if #(.ADDR_W(ADDR_W), .DFX_W(DFX_W)) bus ();

  router_req_issuer #(
    .FIFO_DEPTH     (FIFO_DEPTH),
    .ADDR_W         (ADDR_W),
    .DFX_W          (DFX_W),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .busy        (busy),
    .fifo_count  (fifo_count),
    .done_count  (done_count),
    .err_illegal (err_illegal),
    .err_timeout (err_timeout)
  );

  always #5 clk = ~clk;

  int          vectors = 0;
  int          miscompares = 0;
  logic [15:0] exp_done = '0;

  function automatic tdesc_t cur_out();
    return {bus.router_scr_addr, bus.router_dst_addr, bus.router_src_dfx, bus.router_dst_dfx};
  endfunction

  function automatic tdesc_t rand_desc();
    tdesc_t d;
    d.src  = ADDR_W'($urandom);
    d.dst  = ADDR_W'($urandom);
    d.sdfx = DFX_W'($urandom);
    d.ddfx = d.sdfx ^ DFX_W'($urandom_range(1, 3));
    return d;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.desc_valid  = 1'b0;
    bus.router_ack  = 1'b0;
    bus.router_done = 1'b0;
  endtask

  task automatic offer(input tdesc_t d);
    bus.desc_valid    = 1'b1;
    bus.desc_src_addr = d.src;
    bus.desc_dst_addr = d.dst;
    bus.desc_src_dfx  = d.sdfx;
    bus.desc_dst_dfx  = d.ddfx;
  endtask

  task automatic wait_start();
    int n = 0;
    while (!bus.router_start_req && n < 30) begin
      tick();
      n++;
    end
    vectors++;
    if (!bus.router_start_req) begin
      miscompares++;
      $display("FAIL wait_start: start_req=%b after %0d cycles, required 1", bus.router_start_req, n);
    end
  endtask

  // Checks the issued request, then acks and completes it.
  task automatic serve_expect(input tdesc_t e);
    wait_start();
    vectors++;
    if (cur_out() !== e) begin
      miscompares++;
      $display("FAIL serve_desc: got %h required %h", cur_out(), e);
    end
    bus.router_ack = 1'b1;
    tick();
    bus.router_ack  = 1'b0;
    bus.router_done = 1'b1;
    tick();
    bus.router_done = 1'b0;
    exp_done++;
    vectors++;
    if (done_count !== exp_done) begin
      miscompares++;
      $display("FAIL serve_done_count: got %0d required %0d", done_count, exp_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle_inputs();
    bus.desc_src_addr = '0; bus.desc_dst_addr = '0; bus.desc_src_dfx = '0; bus.desc_dst_dfx = '0;
    tick();
    tick();
    vectors++;
    if ({bus.router_start_req, busy, err_illegal, err_timeout} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: start/busy/ill/tmo=%b required 0000",
               {bus.router_start_req, busy, err_illegal, err_timeout});
    end
    vectors++;
    if (bus.desc_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_ready: got %b required 1", bus.desc_ready);
    end
    vectors++;
    if (fifo_count !== 3'd0 || done_count !== 16'd0 || cur_out() !== '0) begin
      miscompares++;
      $display("FAIL reset_regs: count=%0d done=%0d out=%h required 0 0 0",
               fifo_count, done_count, cur_out());
    end
    rst = 1'b0;
    exp_done = '0;
    tick();
  endtask

  task automatic test_single();
    tdesc_t d = {10'h001, 10'h005, 2'b01, 2'b10};
    offer(d);                        // cycle N
    tick();
    bus.desc_valid = 1'b0;           // N+1
    vectors++;
    if (bus.router_start_req !== 1'b0 || fifo_count !== 3'd1) begin
      miscompares++;
      $display("FAIL single_n1: start=%b count=%0d required 0 1", bus.router_start_req, fifo_count);
    end
    tick();                          // N+2
    vectors++;
    if (bus.router_start_req !== 1'b1 || cur_out() !== d) begin
      miscompares++;
      $display("FAIL single_n2: start=%b out=%h required 1 %h", bus.router_start_req, cur_out(), d);
    end
    tick();
    tick();                          // N+4
    bus.router_ack = 1'b1;
    tick();                          // N+5
    bus.router_ack = 1'b0;
    vectors++;
    if (bus.router_start_req !== 1'b0 || cur_out() !== d) begin
      miscompares++;
      $display("FAIL single_n5: start=%b out=%h required 0 %h", bus.router_start_req, cur_out(), d);
    end
    tick();
    tick();                          // N+7
    bus.router_done = 1'b1;
    tick();                          // N+8
    bus.router_done = 1'b0;
    exp_done++;
    vectors++;
    if (done_count !== exp_done || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL single_n8: done=%0d busy=%b required %0d 1", done_count, busy, exp_done);
    end
    tick();                          // N+9
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL single_n9_busy: got %b required 0", busy);
    end
  endtask

  task automatic test_fill();
    tdesc_t d0 = rand_desc();
    tdesc_t q[5];
    for (int i = 0; i < 5; i++) q[i] = rand_desc();
    offer(d0);
    tick();
    bus.desc_valid = 1'b0;
    wait_start();                    // d0 now held waiting for ack
    for (int i = 0; i < 4; i++) begin
      offer(q[i]);
      tick();
    end
    offer(q[4]);
    vectors++;
    if (fifo_count !== 3'd4 || bus.desc_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL fill_full: count=%0d ready=%b required 4 0", fifo_count, bus.desc_ready);
    end
    tick();
    vectors++;
    if (fifo_count !== 3'd4) begin
      miscompares++;
      $display("FAIL fill_blocked: count=%0d required 4", fifo_count);
    end
    bus.router_ack = 1'b1;
    tick();
    bus.router_ack  = 1'b0;
    bus.router_done = 1'b1;
    tick();                          // GAP
    bus.router_done = 1'b0;
    exp_done++;
    tick();                          // IDLE, pops q[0]
    tick();
    vectors++;
    if (fifo_count !== 3'd3 || bus.desc_ready !== 1'b1 || cur_out() !== q[0]) begin
      miscompares++;
      $display("FAIL fill_after_pop: count=%0d ready=%b out=%h required 3 1 %h",
               fifo_count, bus.desc_ready, cur_out(), q[0]);
    end
    tick();
    bus.desc_valid = 1'b0;
    vectors++;
    if (fifo_count !== 3'd4) begin
      miscompares++;
      $display("FAIL fill_fifth_accept: count=%0d required 4", fifo_count);
    end
    for (int i = 0; i < 5; i++) serve_expect(q[i]);
    tick();
    vectors++;
    if (fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL fill_drained: count=%0d required 0", fifo_count);
    end
  endtask

  task automatic test_illegal();
    tdesc_t d = rand_desc();
    tick();
    tick();
    d.sdfx = 2'b11;
    d.ddfx = 2'b11;
    offer(d);
    vectors++;
    if (bus.desc_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL illegal_ready: got %b required 1", bus.desc_ready);
    end
    tick();
    bus.desc_valid = 1'b0;
    vectors++;
    if (err_illegal !== 1'b1 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL illegal_pulse: err=%b count=%0d required 1 0", err_illegal, fifo_count);
    end
    tick();
    vectors++;
    if (err_illegal !== 1'b0) begin
      miscompares++;
      $display("FAIL illegal_once: err=%b required 0", err_illegal);
    end
    for (int i = 0; i < 4; i++) begin
      vectors++;
      if (bus.router_start_req !== 1'b0 || busy !== 1'b0) begin
        miscompares++;
        $display("FAIL illegal_no_req: start=%b busy=%b required 0 0", bus.router_start_req, busy);
      end
      tick();
    end
  endtask

  task automatic test_ack_done_same();
    tdesc_t q0 = rand_desc();
    tdesc_t q1 = rand_desc();
    offer(q0);
    tick();
    offer(q1);
    tick();
    bus.desc_valid = 1'b0;
    wait_start();
    vectors++;
    if (cur_out() !== q0) begin
      miscompares++;
      $display("FAIL same_q0: got %h required %h", cur_out(), q0);
    end
    bus.router_ack  = 1'b1;
    bus.router_done = 1'b1;
    tick();                          // GAP
    idle_inputs();
    exp_done++;
    vectors++;
    if (bus.router_start_req !== 1'b0 || done_count !== exp_done || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL same_gap: start=%b done=%0d busy=%b required 0 %0d 1",
               bus.router_start_req, done_count, busy, exp_done);
    end
    tick();                          // IDLE
    vectors++;
    if (bus.router_start_req !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL same_idle: start=%b busy=%b required 0 0", bus.router_start_req, busy);
    end
    tick();
    vectors++;
    if (bus.router_start_req !== 1'b1 || cur_out() !== q1) begin
      miscompares++;
      $display("FAIL same_next: start=%b out=%h required 1 %h", bus.router_start_req, cur_out(), q1);
    end
    serve_expect(q1);
    tick();
  endtask

  task automatic test_reset_mid();
    tdesc_t q0 = rand_desc();
    tdesc_t q1 = rand_desc();
    tdesc_t q2 = rand_desc();
    offer(q0);
    tick();
    offer(q1);
    tick();
    bus.desc_valid = 1'b0;
    wait_start();
    bus.router_ack = 1'b1;
    tick();                          // WAIT_DONE, q1 still queued
    bus.router_ack = 1'b0;
    #2 rst = 1'b1;
    #1;
    vectors++;
    if (bus.router_start_req !== 1'b0 || fifo_count !== 3'd0 || done_count !== 16'd0 ||
        bus.desc_ready !== 1'b1 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_mid: start=%b count=%0d done=%0d ready=%b busy=%b required 0 0 0 1 0",
               bus.router_start_req, fifo_count, done_count, bus.desc_ready, busy);
    end
    tick();
    rst = 1'b0;
    exp_done = '0;
    tick();
    offer(q2);
    tick();
    bus.desc_valid = 1'b0;
    serve_expect(q2);
    tick();
  endtask

  task automatic test_random();
    tdesc_t      exp_q[$];
    tdesc_t      held = '0;
    tdesc_t      d, e;
    logic        prev_start = 1'b0, drop_exp = 1'b0, ill_prev = 1'b0, waiting = 1'b0;
    int unsigned ack_wait = 0, done_wait = 0;
    for (int c = 0; c < 2000; c++) begin
      vectors++;
      if (err_illegal !== ill_prev) begin
        miscompares++;
        $display("FAIL rnd_err_illegal c%0d: got %b required %b", c, err_illegal, ill_prev);
      end
      vectors++;
      if (done_count !== exp_done) begin
        miscompares++;
        $display("FAIL rnd_done_count c%0d: got %0d required %0d", c, done_count, exp_done);
      end
      if (drop_exp) begin
        vectors++;
        if (bus.router_start_req !== 1'b0) begin
          miscompares++;
          $display("FAIL rnd_drop c%0d: start=%b required 0", c, bus.router_start_req);
        end
      end
      if (bus.router_start_req && !prev_start) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_spurious_req c%0d: start=1 with no queued descriptor, required 0", c);
        end else begin
          e = exp_q.pop_front();
          if (cur_out() !== e) begin
            miscompares++;
            $display("FAIL rnd_issue c%0d: got %h required %h", c, cur_out(), e);
          end
        end
        held     = cur_out();
        ack_wait = $urandom_range(0, 3);
      end else if (bus.router_start_req) begin
        vectors++;
        if (cur_out() !== held) begin
          miscompares++;
          $display("FAIL rnd_hold c%0d: got %h required %h", c, cur_out(), held);
        end
      end
      if (c >= 600 && exp_q.size() == 0 && !bus.router_start_req && !waiting) break;

      bus.desc_valid = (c < 600) && ($urandom_range(0, 1) == 1);
      d = rand_desc();
      if ($urandom_range(0, 5) == 0) d.ddfx = d.sdfx;
      offer(d);
      bus.desc_valid = (c < 600) && ($urandom_range(0, 1) == 1);
      if (bus.router_start_req) begin
        bus.router_ack = (ack_wait == 0);
        if (ack_wait != 0) ack_wait--;
      end else begin
        bus.router_ack = ($urandom_range(0, 3) == 0);
      end
      if (waiting) begin
        bus.router_done = (done_wait == 0);
        if (done_wait != 0) done_wait--;
      end else begin
        bus.router_done = ($urandom_range(0, 3) == 0);
      end

      ill_prev = bus.desc_valid && bus.desc_ready && (d.sdfx == d.ddfx);
      if (bus.desc_valid && bus.desc_ready && (d.sdfx != d.ddfx)) exp_q.push_back(d);
      drop_exp = bus.router_start_req && bus.router_ack;
      if (bus.router_start_req && bus.router_ack) begin
        if (bus.router_done) exp_done++;
        else begin
          waiting   = 1'b1;
          done_wait = $urandom_range(0, 2);
        end
      end else if (waiting && bus.router_done) begin
        exp_done++;
        waiting = 1'b0;
      end
      prev_start = bus.router_start_req;
      tick();
    end
    idle_inputs();
    vectors++;
    if (exp_q.size() != 0 || fifo_count !== 3'd0) begin
      miscompares++;
      $display("FAIL rnd_drain: model left %0d, fifo_count=%0d, required 0 0", exp_q.size(),
               fifo_count);
    end
    tick();
    tick();
  endtask

`ifdef ROUTER_REQ_TIMEOUT_EN
  task automatic test_timeout();
    tdesc_t q0 = rand_desc();
    tdesc_t q1 = rand_desc();
    offer(q0);
    tick();
    offer(q1);
    tick();
    bus.desc_valid = 1'b0;
    wait_start();                    // cycle S
    for (int k = 1; k < 8; k++) begin
      tick();
      vectors++;
      if (err_timeout !== 1'b0 || bus.router_start_req !== 1'b1) begin
        miscompares++;
        $display("FAIL tmo_early S+%0d: err=%b start=%b required 0 1", k, err_timeout,
                 bus.router_start_req);
      end
    end
    tick();                          // S+8
    vectors++;
    if (err_timeout !== 1'b1 || bus.router_start_req !== 1'b0 || done_count !== exp_done) begin
      miscompares++;
      $display("FAIL tmo_abort: err=%b start=%b done=%0d required 1 0 %0d", err_timeout,
               bus.router_start_req, done_count, exp_done);
    end
    tick();
    vectors++;
    if (err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL tmo_once: err=%b required 0", err_timeout);
    end
    tick();                          // S+10: next request after GAP
    vectors++;
    if (bus.router_start_req !== 1'b1) begin
      miscompares++;
      $display("FAIL tmo_next: start=%b required 1", bus.router_start_req);
    end
    serve_expect(q1);
    tick();
  endtask
`else
  task automatic test_no_timeout();
    tdesc_t q0 = rand_desc();
    offer(q0);
    tick();
    bus.desc_valid = 1'b0;
    wait_start();
    repeat (20) tick();
    vectors++;
    if (bus.router_start_req !== 1'b1 || err_timeout !== 1'b0) begin
      miscompares++;
      $display("FAIL no_tmo_hold: start=%b err=%b required 1 0", bus.router_start_req,
               err_timeout);
    end
    serve_expect(q0);
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_illegal();
    test_ack_done_same();
    test_reset_mid();
    test_random();
`ifdef ROUTER_REQ_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
